pipe_stage_reg: RTL

- Generic, parametrised inter-stage pipeline register for the 5-stage core. It replaces the fixed per-stage register banks (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque packed payload with a valid/ready handshake, so back-pressure, stalls and hazard bubbles work without stage-specific logic.
- Supports a synchronous pipeline flush for branch-taken.
- With SKID=1, adds a 2-entry skid buffer so in_ready is registered and full throughput is kept.
- Exports a saturating stall counter for performance monitoring.

---
 rtl/core_pipe_pkg.sv | 35 +++
 rtl/pipe_stall_counter.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 3 files changed

// File: rtl/core_pipe_pkg.sv
// Shared pipeline definitions: payload layouts and
// stage-register state encoding for the 5-stage core.
package core_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int XLEN = 32;

    // ID/EX payload, LSB first: dst, reg2, val2, val1,
    // mem_w, mem_r, branch, ex_cmd, wb_en, pc.
    localparam int DST_LSB    = 0;
    localparam int DST_W      = 5;
    localparam int REG2_LSB   = DST_LSB + DST_W;
    localparam int VAL2_LSB   = REG2_LSB + XLEN;
    localparam int VAL1_LSB   = VAL2_LSB + XLEN;
    localparam int MEM_W_BIT  = VAL1_LSB + XLEN;
    localparam int MEM_R_BIT  = MEM_W_BIT + 1;
    localparam int BRANCH_BIT = MEM_R_BIT + 1;
    localparam int EX_CMD_LSB = BRANCH_BIT + 1;
    localparam int EX_CMD_W   = 4;
    localparam int WB_EN_BIT  = EX_CMD_LSB + EX_CMD_W;
    localparam int PC_LSB     = WB_EN_BIT + 1;
    localparam int ID_EX_W    = PC_LSB + XLEN;

    // EX/MEM: pc, wb_en, mem_r, mem_w, alu, store data, dst.
    localparam int EX_MEM_W = XLEN + 3 + XLEN + XLEN + DST_W;

    // MEM/WB: wb_en, mem_r, alu, load data, dst.
    localparam int MEM_WB_W = 2 + XLEN + XLEN + DST_W;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating performance counter with synchronous
// clear that wins over increment.
module pipe_stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    import core_pipe_pkg::*;

    localparam logic [CNT_W-1:0] ONE =
        {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next count: clear, else saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready inter-stage register with optional
// 2-entry skid buffer, flush and stall counter.
module pipe_stage_reg #(
    parameter int DATA_W         = 32,
    parameter int SKID           = 0,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);
    import core_pipe_pkg::*;

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              in_xfer;
    logic              out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = m_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // next state and payload moves; flush overrides all
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_FULL;
                    m_d     = in_data;
                end
            end
            ST_FULL: begin
                if (in_xfer && out_xfer) begin
                    m_d = in_data;
                end else if (in_xfer) begin
                    state_d = ST_SKID;
                    s_d     = in_data;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_xfer) begin
                    state_d = ST_FULL;
                    m_d     = s_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                m_d = '0;
                s_d = '0;
            end
        end
    end

    // state and payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    if (SKID != 0) begin : g_skid
        logic rdy_q, rdy_d;

        // ready is a flop: low only while both entries hold
        always_comb begin
            rdy_d = (state_d != ST_SKID);
        end

        // registered ready, low through reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdy_q <= 1'b0;
            end else begin
                rdy_q <= rdy_d;
            end
        end

        assign in_ready = rdy_q;
    end else begin : g_noskid
        assign in_ready = !out_valid | out_ready;
    end

    pipe_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid & ~out_ready),
        .clr (stall_clr),
        .cnt (stall_cnt)
    );

endmodule
